// File: rtl/ps2_pkg.sv
// Shared types, constants and the Set-2 scan-code to ASCII map used by the
// PS/2 letter receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    // Returns {hit, ascii}; hit is 0 for codes the game does not use.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
        logic [8:0] res;
        res = 9'h000;
        case (code)
            8'h1C: res = {1'b1, 8'h41};
            8'h32: res = {1'b1, 8'h42};
            8'h21: res = {1'b1, 8'h43};
            8'h23: res = {1'b1, 8'h44};
            8'h24: res = {1'b1, 8'h45};
            8'h2B: res = {1'b1, 8'h46};
            8'h34: res = {1'b1, 8'h47};
            8'h33: res = {1'b1, 8'h48};
            8'h43: res = {1'b1, 8'h49};
            8'h3B: res = {1'b1, 8'h4A};
            8'h42: res = {1'b1, 8'h4B};
            8'h4B: res = {1'b1, 8'h4C};
            8'h3A: res = {1'b1, 8'h4D};
            8'h31: res = {1'b1, 8'h4E};
            8'h44: res = {1'b1, 8'h4F};
            8'h4D: res = {1'b1, 8'h50};
            8'h15: res = {1'b1, 8'h51};
            8'h2D: res = {1'b1, 8'h52};
            8'h1B: res = {1'b1, 8'h53};
            8'h2C: res = {1'b1, 8'h54};
            8'h3C: res = {1'b1, 8'h55};
            8'h2A: res = {1'b1, 8'h56};
            8'h1D: res = {1'b1, 8'h57};
            8'h22: res = {1'b1, 8'h58};
            8'h35: res = {1'b1, 8'h59};
            8'h1A: res = {1'b1, 8'h5A};
            8'h29: res = {1'b1, ASCII_SPACE};
            8'h66: res = {1'b1, ASCII_BS};
            8'h5A: res = {1'b1, ASCII_CR};
            default: res = 9'h000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_letter_rx_frame.sv
// PS/2 line conditioning and 11-bit frame deframer: synchronisers, clock
// glitch filter, frame FSM and mid-frame timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_ok,
    output logic       byte_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          filt_prev;
    logic          strike;
    logic          data_bit;

    frame_state_t  state;
    frame_state_t  state_next;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          parity;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;
    logic          stop_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_cnt  <= '0;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_prev <= filt_clk;
            // Any sample agreeing with the filtered level restarts the run.
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign strike   = filt_prev & ~filt_clk;
    assign data_bit = data_sync[1];
    assign timeout  = (state != IDLE) && (tmo_cnt == TMO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (strike) begin
            case (state)
                IDLE:    state_next = data_bit ? IDLE : DATA;
                DATA:    state_next = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= '0;
            bit_cnt <= '0;
            parity  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE || strike || timeout) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (strike && !timeout) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  parity <= data_bit;
                    default: ;
                endcase
            end
        end
    end

    assign stop_good = data_bit & (^{shift, parity});

    always_comb begin
        byte_ok  = 1'b0;
        byte_err = 1'b0;
        if (timeout) begin
            byte_err = 1'b1;
        end else if (strike && state == STOP) begin
            byte_ok  = stop_good;
            byte_err = ~stop_good;
        end
    end

    assign byte_out = shift;

endmodule

// File: rtl/ps2_letter_rx.sv
// PS/2 keyboard receiver for the typing game: turns Set-2 scan-code frames
// into single-cycle ASCII letter strobes, ignoring breaks, extended keys and
// typematic repeats.
module ps2_letter_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_ok;
    logic       rx_err;
    logic       brk;
    logic       ext;
    logic [7:0] last_make;
    logic [8:0] map;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_out (rx_byte),
        .byte_ok  (rx_ok),
        .byte_err (rx_err)
    );

    assign map = scan_to_ascii(rx_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            letter       <= 8'h00;
            letter_valid <= 1'b0;
            frame_err    <= 1'b0;
            brk          <= 1'b0;
            ext          <= 1'b0;
            last_make    <= 8'h00;
        end else begin
            letter_valid <= 1'b0;
            frame_err    <= rx_err;
            if (rx_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (rx_ok) begin
                if (rx_byte == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    // Releasing the held key re-arms it for the next press.
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (rx_byte == last_make) begin
                        last_make <= 8'h00;
                    end
                end else if (ext) begin
                    ext <= 1'b0;
                end else if (rx_byte != last_make && map[8]) begin
                    letter       <= map[7:0];
                    letter_valid <= 1'b1;
                    last_make    <= rx_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_letter_rx.sv
// Directed self-checking bench for ps2_letter_rx: drives bit-level PS/2 frames
// and checks strobe counts and letter values against hand-computed results.
module tb_ps2_letter_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] letter;
    logic       letter_valid;
    logic       frame_err;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;
    int overlap_cnt;
    int v0;
    int e0;

    ps2_letter_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .letter       (letter),
        .letter_valid (letter_valid),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (letter_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (letter_valid && frame_err) overlap_cnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sendBit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (4) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (8) @(posedge clk);
        end else begin
            repeat (15) @(posedge clk);
        end
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input bit bad_parity, input bit glitch);
        logic par;
        par = (~^code) ^ bad_parity;
        sendBit(1'b0, glitch);
        for (int i = 0; i < 8; i++) sendBit(code[i], glitch);
        sendBit(par, glitch);
        sendBit(1'b1, glitch);
        ps2_data = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    task automatic sendPartial(input logic [7:0] code, input int nbits);
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) sendBit(code[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic mark();
        @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        checks = 0; errors = 0; valid_cnt = 0; err_cnt = 0; overlap_cnt = 0;
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_letter", 32'(letter), 32'h00);
        checkOutput("reset_valid", 32'(letter_valid), 32'h0);
        checkOutput("reset_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Press, break, release of A.
        mark();
        applyStimulus(8'h1C, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("a_press_count", 32'(valid_cnt - v0), 32'd1);
        checkOutput("a_press_letter", 32'(letter), 32'h41);
        checkOutput("a_press_err", 32'(err_cnt - e0), 32'd0);

        // Typematic repeats suppressed until release.
        mark();
        for (int i = 0; i < 3; i++) applyStimulus(8'h1C, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("typematic_count", 32'(valid_cnt - v0), 32'd2);
        checkOutput("typematic_letter", 32'(letter), 32'h41);
        checkOutput("typematic_err", 32'(err_cnt - e0), 32'd0);

        // Parity error then good space.
        mark();
        applyStimulus(8'h29, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("parity_err_count", 32'(err_cnt - e0), 32'd1);
        checkOutput("parity_valid_count", 32'(valid_cnt - v0), 32'd0);
        mark();
        applyStimulus(8'h29, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("space_count", 32'(valid_cnt - v0), 32'd1);
        checkOutput("space_letter", 32'(letter), 32'h20);

        // Extended key make/break ignored, then enter.
        mark();
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ext_count", 32'(valid_cnt - v0), 32'd0);
        applyStimulus(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("enter_count", 32'(valid_cnt - v0), 32'd1);
        checkOutput("enter_letter", 32'(letter), 32'h0D);
        checkOutput("enter_err", 32'(err_cnt - e0), 32'd0);

        // Abandoned frame times out.
        mark();
        sendPartial(8'h55, 4);
        repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_err_count", 32'(err_cnt - e0), 32'd1);
        checkOutput("timeout_valid_count", 32'(valid_cnt - v0), 32'd0);
        checkOutput("timeout_fsm_idle", 32'(dut.u_frame.state), 32'(IDLE));
        mark();
        applyStimulus(8'h1A, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("z_count", 32'(valid_cnt - v0), 32'd1);
        checkOutput("z_letter", 32'(letter), 32'h5A);

        // Short clock glitches around every bit of a B frame.
        mark();
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        applyStimulus(8'h32, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("glitch_count", 32'(valid_cnt - v0), 32'd1);
        checkOutput("glitch_letter", 32'(letter), 32'h42);
        checkOutput("glitch_err", 32'(err_cnt - e0), 32'd0);

        // Reset in the middle of a frame.
        sendPartial(8'h1C, 3);
        repeat (3) @(posedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_letter", 32'(letter), 32'h00);
        checkOutput("midrst_valid", 32'(letter_valid), 32'h0);
        checkOutput("midrst_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        mark();
        repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_strobe", 32'(valid_cnt - v0), 32'd0);
        checkOutput("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("after_rst_count", 32'(valid_cnt - v0), 32'd1);
        checkOutput("after_rst_letter", 32'(letter), 32'h41);

        checkOutput("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_letter_rx.md
# ps2_letter_rx

Receives key presses from a PS/2 keyboard and delivers them as ASCII codes to the typing-game level displays and checkers. It filters and synchronises the PS/2 clock and data lines, deframes 11-bit scan-code frames, and tracks break (0xF0) and extended (0xE0) prefixes. Each qualifying key press produces one `letter` byte with a single-cycle valid strobe. It is the producer of the `letter` input consumed by the level display blocks.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised `ps2_clk` samples required before the filtered level changes.
- `TIMEOUT_CYCLES`, 200000: `clk` cycles without a filtered falling edge mid-frame before the frame is abandoned.
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data, asynchronous to `clk`.
- `letter` output 8: ASCII code of the last accepted key; holds its value between strobes.
- `letter_valid` output 1: one-cycle pulse; `letter` is new in the same cycle.
- `frame_err` output 1: one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation
- Both inputs pass through 2-flop synchronisers. Synchronised `ps2_clk` feeds a saturating filter counter. The filtered level flips only after `FILTER_LEN` equal samples that differ from the current filtered level. The filtered level resets to 1.
- A falling edge of the filtered clock is the sample strike. Data is sampled from synchronised `ps2_data` in that cycle.
- Frame FSM has four states:
  - IDLE: on strike with data 0 → DATA, bit count 0. Data 1 is ignored; stay in IDLE.
  - DATA: shift in 8 bits LSB first. After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: byte is good if data is 1 and data bits plus parity have odd weight. Otherwise pulse `frame_err`. Return to IDLE.
- Timeout: in any non-IDLE state, a counter reaches `TIMEOUT_CYCLES` since the last strike → IDLE, pulse `frame_err`, discard the partial byte.
- Good bytes go to the decode layer. Flags are `brk` and `ext`, plus an 8-bit `last_make`.
  - 0xF0 sets `brk`. 0xE0 sets `ext`. Neither produces output.
  - Other byte with `brk` set: clear `brk` and `ext`. If the byte equals `last_make`, clear `last_make` to 0x00. No output.
  - Other byte with `ext` set (no `brk`): clear `ext`. No output; extended keys are ignored.
  - Plain make code equal to `last_make`: typematic repeat, suppressed.
  - Plain make code, mapped: output its ASCII and set `last_make` to the code.
  - Plain make code, unmapped: no output; `last_make` is unchanged.
- Set-2 map:
  - Letters A–Z map to uppercase 0x41–0x5A: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - 0x29 → 0x20 (space), 0x66 → 0x08 (backspace), 0x5A → 0x0D (enter).
- A byte with a parity or stop error clears `brk` and `ext`. `last_make` is kept.
- Reset values: `letter` 0x00, `letter_valid` 0, `frame_err` 0, FSM IDLE, `brk`/`ext` 0, `last_make` 0x00, filtered clock 1, counters 0.

## Timing
- Strike detection lags the raw `ps2_clk` fall by 2 synchroniser cycles plus `FILTER_LEN` cycles.
- `letter_valid`/`frame_err` assert exactly 1 `clk` after the cycle of the stop-bit strike. For a timeout, `frame_err` asserts 1 cycle after the counter hits the limit.
- At most one of `letter_valid` and `frame_err` is high in any cycle.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no strike.
- Asynchronous reset mid-frame: all state clears immediately. The next start bit begins a fresh frame. No strobe is produced for the interrupted frame.
- Timeout counter resets on every strike and is held at 0 in IDLE.

## Structure
- Shared package `ps2_pkg`:
  - frame-state enum (IDLE, DATA, PARITY, STOP);
  - constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `ASCII_SPACE`, `ASCII_BS`, `ASCII_CR`;
  - scan-code-to-ASCII function returning {hit, ascii}.
- Sub-module `ps2_frame_rx` contains the synchronisers, filter, frame FSM and timeout. Its outputs are `byte_out[7:0]`, `byte_ok` and `byte_err` pulses. The top level holds the decode layer and output registers.

## Test plan
- Frame 0x1C (odd parity bit 0, stop 1), then F0 1C → exactly one `letter_valid`; `letter`=0x41; `frame_err` never asserts.
- Make 0x1C sent three times (typematic), then F0 1C, then 0x1C → two strobes, both with 0x41.
- Frame 0x29 with parity bit flipped → `frame_err` pulse, no `letter_valid`; next good 0x29 gives `letter`=0x20.
- E0 75 then E0 F0 75, then 0x5A → no strobe for the extended key; one strobe with 0x0D.
- Start bit plus 4 data bits, then silence for `TIMEOUT_CYCLES` → one `frame_err`, FSM back in IDLE. A following full 0x1A frame gives 0x5A.
- 3-cycle low glitches on `ps2_clk` (`FILTER_LEN`=8) interleaved with valid frame 0x32 → single strobe with 0x42. `rst_n` pulsed low mid-frame → no strobe; outputs return to reset values.
